// File: rtl/pipeline_fetch_ctrl.sv
// pipeline_fetch_ctrl: credit-based fetch, in-order instruction queue and stage occupancy tracking; `PERF_CNT_EN adds retire/flush counters
module pipeline_fetch_ctrl #(
  parameter int XLEN = 32,
  parameter int NUM_STAGES = 5,
  parameter int IQ_DEPTH = 4,
  parameter int CNT_W = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  input  logic                  imem_ready,
  output logic [XLEN-1:0]       imem_addr,
  input  logic                  imem_rvalid,
  input  logic [XLEN-1:0]       imem_rdata,
  input  logic                  redir_valid,
  input  logic [XLEN-1:0]       redir_pc,
  input  logic                  stall,
  output logic                  insn_valid,
  output logic [XLEN-1:0]       insn_data,
  output logic [XLEN-1:0]       insn_pc,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  retire,
  output logic [CNT_W-1:0]      cycle_cnt
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);
  localparam int AW = $clog2(IQ_DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = AW + 2;
  logic [XLEN-1:0] pc;
  logic [CW-1:0] inflight, discard, q_count;
  logic [AW-1:0] q_wp, q_rp, f_wp, f_rp;
  logic [XLEN-1:0] q_data [IQ_DEPTH];
  logic [XLEN-1:0] q_pc [IQ_DEPTH];
  logic [XLEN-1:0] f_pc [IQ_DEPTH];
  logic [UW-1:0] used;
  logic acc, resp, drop, push, pop;
  always_comb begin
    used = {1'b0, inflight} + {1'b0, q_count};
    imem_req = rst_n && !redir_valid && used < UW'(IQ_DEPTH);
    acc = imem_req && imem_ready;
    resp = imem_rvalid && inflight != '0;
    drop = discard != '0;
    push = resp && !drop && !redir_valid;
    insn_valid = q_count != '0;
    pop = insn_valid && !stall && !redir_valid;
    imem_addr = pc;
    insn_data = insn_valid ? q_data[q_rp] : '0;
    insn_pc = insn_valid ? q_pc[q_rp] : '0;
    retire = stage_valid[NUM_STAGES-1] && !stall;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      inflight <= '0;
      discard <= '0;
      q_count <= '0;
      q_wp <= '0;
      q_rp <= '0;
      f_wp <= '0;
      f_rp <= '0;
      stage_valid <= '0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      inflight <= inflight + CW'(acc) - CW'(resp);
      f_wp <= f_wp + AW'(acc);
      f_rp <= f_rp + AW'(resp);
      if (redir_valid) begin
        pc <= redir_pc & ~XLEN'(3);
        q_count <= '0;
        q_wp <= '0;
        q_rp <= '0;
        discard <= inflight - CW'(resp);
        stage_valid <= {stall ? stage_valid[NUM_STAGES-1] : stage_valid[NUM_STAGES-2], (NUM_STAGES-1)'(0)};
      end else begin
        pc <= acc ? pc + XLEN'(4) : pc;
        discard <= discard - CW'(resp && drop);
        q_count <= q_count + CW'(push) - CW'(pop);
        q_wp <= q_wp + AW'(push);
        q_rp <= q_rp + AW'(pop);
        stage_valid <= stall ? stage_valid : {stage_valid[NUM_STAGES-2:0], insn_valid};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc) f_pc[f_wp] <= pc;
    if (push) begin
      q_data[q_wp] <= imem_rdata;
      q_pc[q_wp] <= f_pc[f_rp];
    end
  end
`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      retire_cnt <= retire_cnt + CNT_W'(retire);
      flush_cnt <= flush_cnt + CNT_W'(redir_valid);
    end
  end
`endif
  a_rvalid_credit: assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> inflight != '0);
  a_queue_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && q_count == CW'(IQ_DEPTH)));
endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// tb_pipeline_fetch_ctrl: scoreboard bench with an in-order memory model for pipeline_fetch_ctrl
module tb_pipeline_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_ready = 1'b0;
  logic imem_rvalid = 1'b0;
  logic redir_valid = 1'b0;
  logic stall = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] redir_pc = '0;
  logic imem_req, insn_valid, retire;
  logic [31:0] imem_addr, insn_data, insn_pc;
  logic [4:0] stage_valid;
  logic [15:0] cycle_cnt;
`ifdef PERF_CNT_EN
  logic [15:0] retire_cnt, flush_cnt;
`endif
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [31:0] a;
    int due;
  } req_t;
  req_t pend[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc = '0;
  logic [31:0] first_pc = '0;
  logic [4:0] sv_m = '0;
  int cyc = 0;
  int lat = 1;
  int allow = 0;
  int n_acc = 0;
  int n_ret = 0;
  logic hold = 1'b0;
  logic want_first = 1'b0;

  pipeline_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .stall(stall), .insn_valid(insn_valid), .insn_data(insn_data), .insn_pc(insn_pc),
    .stage_valid(stage_valid), .retire(retire), .cycle_cnt(cycle_cnt)
`ifdef PERF_CNT_EN
    , .retire_cnt(retire_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_clear;
    pend.delete();
    exp_q.delete();
    exp_pc = '0;
    sv_m = '0;
    cyc = 0;
    n_acc = 0;
    n_ret = 0;
    hold = 1'b0;
    allow = 0;
    want_first = 1'b0;
  endtask

  task automatic restart;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redir_valid = 1'b0;
    stall = 1'b0;
    lat = 1;
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic tick;
    req_t r;
    logic [63:0] e;
    logic disp;
    if (pend.size() > 0 && pend[0].due <= cyc && (!hold || allow > 0)) begin
      if (hold) allow--;
      r = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata = mem(r.a);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = '0;
    end
    #1;
    if (redir_valid) begin
      exp_q.delete();
      exp_pc = redir_pc & ~32'h3;
    end
    if (imem_req && imem_ready) begin
      total++;
      if (imem_addr !== exp_pc) begin
        bad++;
        $display("FAIL fetch_addr got=%h exp=%h", imem_addr, exp_pc);
      end
      pend.push_back('{exp_pc, cyc + lat});
      exp_q.push_back({exp_pc, mem(exp_pc)});
      exp_pc += 32'd4;
      n_acc++;
    end
    disp = insn_valid && !stall && !redir_valid;
    if (disp) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dispatch_extra got_pc=%h exp=none", insn_pc);
      end else begin
        e = exp_q.pop_front();
        if ({insn_pc, insn_data} !== e) begin
          bad++;
          $display("FAIL dispatch got=%h/%h exp=%h/%h", insn_pc, insn_data, e[63:32], e[31:0]);
        end
      end
      if (want_first) begin
        first_pc = insn_pc;
        want_first = 1'b0;
      end
    end
    total++;
    if ({stage_valid, retire} !== {sv_m, sv_m[4] && !stall}) begin
      bad++;
      $display("FAIL stages got=%b/%b exp=%b/%b", stage_valid, retire, sv_m, sv_m[4] && !stall);
    end
    if (sv_m[4] && !stall) n_ret++;
    sv_m = redir_valid ? {stall ? sv_m[4] : sv_m[3], 4'b0} : stall ? sv_m : {sv_m[3:0], disp};
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({imem_req, insn_valid, retire, stage_valid, cycle_cnt, insn_data, insn_pc} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b %b %h %h %h exp=all zero", imem_req, insn_valid, retire, stage_valid, cycle_cnt, insn_data, insn_pc);
    end
    total++;
    if (imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr got=%h exp=00000000", imem_addr);
    end
`ifdef PERF_CNT_EN
    total++;
    if ({retire_cnt, flush_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_perf got=%h/%h exp=0/0", retire_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_basic;
    int first = -1;
    restart();
    imem_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k == 7) begin
        total++;
        if ({cycle_cnt, stage_valid} !== {16'd7, 5'h1F}) begin
          bad++;
          $display("FAIL fill_tick7 got=%0d/%b exp=7/11111", cycle_cnt, stage_valid);
        end
      end
      if (retire && first < 0) first = k;
      tick();
    end
    total++;
    if (first != 7) begin
      bad++;
      $display("FAIL first_retire got=%0d exp=7", first);
    end
  endtask

  task automatic test_credit;
    restart();
    imem_ready = 1'b1;
    hold = 1'b1;
    allow = 0;
    repeat (8) tick();
    total++;
    if (n_acc != 4 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL credit_limit got=%0d/%b exp=4/0", n_acc, imem_req);
    end
    allow = 1;
    repeat (6) tick();
    total++;
    if (n_acc != 5) begin
      bad++;
      $display("FAIL credit_return got=%0d exp=5", n_acc);
    end
  endtask

  task automatic test_stall;
    restart();
    lat = 2;
    imem_ready = 1'b1;
    repeat (10) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stall_head got=%b exp=queued insn", insn_valid);
      end else if ({stage_valid, retire, insn_valid, insn_pc} !== {5'h1F, 1'b0, 1'b1, exp_q[0][63:32]}) begin
        bad++;
        $display("FAIL stall_hold got=%b/%b/%b/%h exp=11111/0/1/%h", stage_valid, retire, insn_valid, insn_pc, exp_q[0][63:32]);
      end
    end
    stall = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_redirect;
    restart();
    imem_ready = 1'b1;
    repeat (10) tick();
    hold = 1'b1;
    allow = 0;
    for (int i = 0; i < 10 && pend.size() < 3; i++) tick();
    redir_valid = 1'b1;
    redir_pc = 32'h0000_0103;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL redir_req got=%b exp=0", imem_req);
    end
    tick();
    redir_valid = 1'b0;
    hold = 1'b0;
    total++;
    if ({stage_valid, insn_valid, imem_addr} !== {5'b10000, 1'b0, 32'h100}) begin
      bad++;
      $display("FAIL redir_flush got=%b/%b/%h exp=10000/0/00000100", stage_valid, insn_valid, imem_addr);
    end
    want_first = 1'b1;
    repeat (12) tick();
    total++;
    if (want_first || first_pc !== 32'h100) begin
      bad++;
      $display("FAIL redir_first_pc got=%h exp=00000100", first_pc);
    end
  endtask

  task automatic test_wrap;
    restart();
    imem_ready = 1'b1;
    redir_valid = 1'b1;
    redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    tick();
    total++;
    if (imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL pc_wrap got=%h exp=00000000", imem_addr);
    end
    repeat (8) tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 20 && pend.size() > 0; i++) tick();
    repeat (3) tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 70000 && cycle_cnt !== 16'hFFFF; i++) @(negedge clk);
    total++;
    if (cycle_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL cnt_reach got=%h exp=ffff", cycle_cnt);
    end
    @(negedge clk);
    total++;
    if (cycle_cnt !== 16'h0) begin
      bad++;
      $display("FAIL cnt_wrap got=%h exp=0000", cycle_cnt);
    end
  endtask

  task automatic test_reset_mid;
    restart();
    imem_ready = 1'b1;
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({imem_req, insn_valid, retire, stage_valid, cycle_cnt, insn_data, insn_pc, imem_addr} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%b%b%b %b %h %h %h %h exp=all zero", imem_req, insn_valid, retire, stage_valid, cycle_cnt, insn_data, insn_pc, imem_addr);
    end
    imem_rvalid = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf;
    restart();
    imem_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      redir_valid = (i == 12 || i == 14);
      redir_pc = (i == 12) ? 32'h200 : 32'h300;
      tick();
      redir_valid = 1'b0;
      if (i > 14 && n_ret == 10) break;
    end
    total++;
    if ({retire_cnt, flush_cnt} !== {16'd10, 16'd2}) begin
      bad++;
      $display("FAIL perf_counts got=%0d/%0d exp=10/2", retire_cnt, flush_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({retire_cnt, flush_cnt, cycle_cnt, stage_valid} !== '0) begin
      bad++;
      $display("FAIL perf_reset got=%0d/%0d/%0d/%b exp=0/0/0/0", retire_cnt, flush_cnt, cycle_cnt, stage_valid);
    end
    imem_rvalid = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
